// File: rtl/bus_responder_pkg.sv
// Shared definitions for the cpu-side bus responder: FSM state encoding,
// default MMIO page selector and MMIO register offsets.
// No logic; imported by bus_responder and mmio_regs.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } state_e;

    // bus_addr[13:8] value that maps the 256-word MMIO page over SPRAM
    localparam logic [5:0] MMIO_PAGE_DEF = 6'h3F;

    localparam logic [7:0] REG_DBG     = 8'd0;
    localparam logic [7:0] REG_CNT_LO  = 8'd1;
    localparam logic [7:0] REG_CNT_HI  = 8'd2;
    localparam logic [7:0] REG_SCRATCH = 8'd3;

endpackage

// File: rtl/bus_responder_mmio.sv
// MMIO register file: DBG (2 bits), free-running cycle counter with
// CNT_HI snapshot, SCRATCH; combinational read mux, writes at the clock edge.
// Ports: clk, rst (async high), wr_en/rd_en strobes, offset, wdata, rdata, dbg.
module mmio_regs
    import bus_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [7:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]        dbg_q;
    logic [DATA_W-1:0] scratch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] snap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
        end else begin
            // wraps silently at all-ones
            cnt_q <= cnt_q + CNT_ONE;
            if (wr_en) begin
                case (offset)
                    REG_DBG:     dbg_q     <= wdata[1:0];
                    REG_SCRATCH: scratch_q <= wdata;
                    default:     ;
                endcase
            end
            // Latch the upper half with the same pre-increment value the
            // lower half returns, so LO-then-HI reads are coherent.
            if (rd_en && (offset == REG_CNT_LO)) begin
                snap_q <= cnt_q[CNT_W-1 -: DATA_W];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            REG_DBG:     rdata = {{(DATA_W-2){1'b0}}, dbg_q};
            REG_CNT_LO:  rdata = cnt_q[DATA_W-1:0];
            REG_CNT_HI:  rdata = snap_q;
            REG_SCRATCH: rdata = scratch_q;
            default:     rdata = '0;
        endcase
    end

    assign dbg = dbg_q;

endmodule

// File: rtl/bus_responder.sv
// Target end of the cpu cyc/write/ack bus: fixed-latency SPRAM front plus MMIO page decode.
// Latency: SPRAM write and MMIO ack in cycle 2, SPRAM read ack in cycle 3; one-cycle ack pulse.
// Backpressure: initiator holds cyc/addr until ack; a new request is taken the cycle after ack.
// Ports: clk, rst (async high); bus_addr/bus_wrdata/bus_cyc/bus_write in, bus_rddata/bus_ack out;
//        ram_addr/ram_din/ram_wren/ram_cs out, ram_dout in; dbg0/dbg1 debug outputs.
module bus_responder
    import bus_pkg::*;
#(
    parameter int         ADDR_W    = 14,
    parameter int         DATA_W    = 16,
    parameter logic [5:0] MMIO_PAGE = MMIO_PAGE_DEF,
    parameter int         CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wrdata,
    input  logic              bus_cyc,
    input  logic              bus_write,
    output logic [DATA_W-1:0] bus_rddata,
    output logic              bus_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wren,
    output logic              ram_cs,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              dbg0,
    output logic              dbg1
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rddata_q;
    logic              ack_q;

    logic              is_mmio;
    logic              ram_sel;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [DATA_W-1:0] mmio_rdata;
    logic [1:0]        dbg;

    assign is_mmio = (bus_addr[ADDR_W-1 -: 6] == MMIO_PAGE);

    always_comb begin
        state_d = state_q;
        ram_sel = 1'b0;
        mmio_wr = 1'b0;
        mmio_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_cyc) begin
                    if (is_mmio) begin
                        mmio_wr = bus_write;
                        mmio_rd = !bus_write;
                        state_d = ST_ACK;
                    end else begin
                        ram_sel = 1'b1;
                        state_d = bus_write ? ST_ACK : ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: state_d = ST_ACK;
            // cyc is still high here; ignoring it keeps the ack cycle clean
            ST_ACK:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Gate with rst so the SPRAM never sees a strobe while reset is held,
    // even though the state register already reads IDLE.
    assign ram_cs   = ram_sel && !rst;
    assign ram_wren = ram_cs && bus_write;
    assign ram_addr = bus_addr;
    assign ram_din  = bus_wrdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            rddata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ST_ACK);
            if (mmio_rd) begin
                rddata_q <= mmio_rdata;
            end else if (state_q == ST_RD_WAIT) begin
                rddata_q <= ram_dout;
            end
        end
    end

    mmio_regs #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_regs (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (mmio_wr),
        .rd_en  (mmio_rd),
        .offset (bus_addr[7:0]),
        .wdata  (bus_wrdata),
        .rdata  (mmio_rdata),
        .dbg    (dbg)
    );

    assign bus_rddata = rddata_q;
    assign bus_ack    = ack_q;
    assign dbg0       = dbg[0];
    assign dbg1       = dbg[1];

endmodule
